dmac_nch_datapath: RTL

//  Parametrised N-channel DMAC datapath: latches peripheral requests, arbitrates one channel at a time,

---
 rtl/dmac_nch_datapath.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dmac_nch_datapath.sv
// N-channel DMAC top datapath: request latching, channel arbitration, 4-word descriptor fetch and engine bus muxing.
// Build option: define DMAC_RR_ARB_EN for round-robin arbitration (default is fixed priority, lowest index wins).
module dmac_nch_datapath #(
    parameter int          NUM_CH      = 4,
    parameter int          CH_W        = $clog2(NUM_CH),
    parameter logic [31:0] PERI_BASE   = 32'h0000_0000,
    parameter logic [31:0] PERI_STRIDE = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     dmac_req,
    input  logic                  HReady,
    input  logic [1:0]            M_HResp,
    input  logic [31:0]           MRData,
    input  logic [NUM_CH-1:0]     ch_irq,
    input  logic [32*NUM_CH-1:0]  ch_MAddress,
    input  logic [32*NUM_CH-1:0]  ch_MWData,
    input  logic [2*NUM_CH-1:0]   ch_MTrans,
    input  logic [NUM_CH-1:0]     ch_MWrite,
    input  logic [4*NUM_CH-1:0]   ch_MWStrb,
    input  logic [4*NUM_CH-1:0]   ch_MBurst,
    output logic [NUM_CH-1:0]     channel_en,
    output logic [31:0]           SAddr,
    output logic [31:0]           DAddr,
    output logic [31:0]           TSize,
    output logic [31:0]           Ctrl,
    output logic [31:0]           MAddress,
    output logic [31:0]           MWData,
    output logic [1:0]            MTrans,
    output logic                  MWrite,
    output logic [3:0]            MWStrb,
    output logic [3:0]            MBurst_Size,
    output logic [CH_W-1:0]       active_ch,
    output logic                  irq,
    output logic                  err_irq
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_D = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [31:0] DESC_OFFSET  = 32'h0000_00A0;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         saddr_q, saddr_d;
    logic [31:0]         daddr_q, daddr_d;
    logic [31:0]         tsize_q, tsize_d;
    logic [31:0]         ctrl_q, ctrl_d;
    logic [NUM_CH-1:0]   grant_oh_s;
    logic [NUM_CH-1:0]   clr_s;
    logic [31:0]         fetch_addr_s;
    logic [CH_W-1:0]     pick_s;

`ifdef DMAC_RR_ARB_EN
    logic [CH_W-1:0]     last_q, last_d;

    // Round-robin: first pending channel after the previous winner, wrapping modulo NUM_CH.
    function automatic logic [CH_W-1:0] arb_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] pick;
        logic            found;
        int              c;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (int'(last) + i) % NUM_CH;
            if (!found && req[c]) begin
                pick  = CH_W'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pick_s = arb_pick(pending_q, last_q);
`else
    // Fixed priority: lowest pending index wins.
    function automatic logic [CH_W-1:0] arb_pick(input logic [NUM_CH-1:0] req);
        logic [CH_W-1:0] pick;
        pick = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = CH_W'(i);
            end
        end
        return pick;
    endfunction

    assign pick_s = arb_pick(pending_q);
`endif

    assign grant_oh_s   = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_q;
    assign clr_s        = ((state_q == S_DONE) || (state_q == S_ERR)) ? grant_oh_s : {NUM_CH{1'b0}};
    assign fetch_addr_s = PERI_BASE + (PERI_STRIDE * 32'(grant_q)) + DESC_OFFSET + {28'd0, idx_q, 2'b00};

    // Next-state logic: request latch, arbitration and descriptor fetch sequencing.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        saddr_d   = saddr_q;
        daddr_d   = daddr_q;
        tsize_d   = tsize_q;
        ctrl_d    = ctrl_q;
`ifdef DMAC_RR_ARB_EN
        last_d    = last_q;
`endif
        // A new request on a bit being cleared this cycle must survive.
        pending_d = (pending_q & ~clr_s) | dmac_req;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_FETCH_A;
                    grant_d = pick_s;
                    idx_d   = 2'd0;
`ifdef DMAC_RR_ARB_EN
                    last_d  = pick_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_A: begin
                if (HReady) begin
                    state_d = S_FETCH_D;
                end else begin
                    state_d = S_FETCH_A;
                end
            end
            S_FETCH_D: begin
                if (!HReady) begin
                    state_d = S_FETCH_D;
                end else if (M_HResp == HRESP_ERROR) begin
                    state_d = S_ERR;
                end else begin
                    case (idx_q)
                        2'd0:    saddr_d = MRData;
                        2'd1:    daddr_d = MRData;
                        2'd2:    tsize_d = MRData;
                        2'd3:    ctrl_d  = MRData;
                        default: saddr_d = saddr_q;
                    endcase
                    if (idx_q == 2'd3) begin
                        // An empty transfer never enables the engine.
                        state_d = (tsize_q == 32'd0) ? S_DONE : S_RUN;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_RUN: begin
                if (ch_irq[grant_q]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                ctrl_d  = 32'd0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state; engine bus is passed through only while running.
    always_comb begin
        channel_en  = {NUM_CH{1'b0}};
        MAddress    = 32'd0;
        MWData      = 32'd0;
        MTrans      = HTRANS_IDLE;
        MWrite      = 1'b0;
        MWStrb      = 4'h0;
        MBurst_Size = 4'h0;
        irq         = 1'b0;
        err_irq     = 1'b0;
        case (state_q)
            S_FETCH_A: begin
                MAddress = fetch_addr_s;
                MTrans   = HTRANS_NONSEQ;
                MWStrb   = 4'hF;
            end
            S_RUN: begin
                channel_en  = grant_oh_s;
                MAddress    = ch_MAddress[32*int'(grant_q) +: 32];
                MWData      = ch_MWData[32*int'(grant_q) +: 32];
                MTrans      = ch_MTrans[2*int'(grant_q) +: 2];
                MWrite      = ch_MWrite[grant_q];
                MWStrb      = ch_MWStrb[4*int'(grant_q) +: 4];
                MBurst_Size = ch_MBurst[4*int'(grant_q) +: 4];
            end
            S_DONE: begin
                irq = 1'b1;
            end
            S_ERR: begin
                err_irq = 1'b1;
            end
            default: begin
                irq = 1'b0;
            end
        endcase
    end

    assign SAddr     = saddr_q;
    assign DAddr     = daddr_q;
    assign TSize     = tsize_q;
    assign Ctrl      = ctrl_q;
    assign active_ch = grant_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= {NUM_CH{1'b0}};
            grant_q   <= {CH_W{1'b0}};
            idx_q     <= 2'd0;
            saddr_q   <= 32'd0;
            daddr_q   <= 32'd0;
            tsize_q   <= 32'd0;
            ctrl_q    <= 32'd0;
`ifdef DMAC_RR_ARB_EN
            // Start the search at channel 0 after reset.
            last_q    <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            saddr_q   <= saddr_d;
            daddr_q   <= daddr_d;
            tsize_q   <= tsize_d;
            ctrl_q    <= ctrl_d;
`ifdef DMAC_RR_ARB_EN
            last_q    <= last_d;
`endif
        end
    end

endmodule
